// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - dual-core dcache/icache RAM arbiter with MSI snoop and cache-to-cache forwarding
module coherence_bus_ctrl #(
    parameter int SNOOP_LAT = 1,
    parameter int WORD_W    = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    input  logic [1:0]             cctrans,
    input  logic [1:0]             ccwrite,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    output logic [1:0]             ccwait,
    output logic [1:0]             ccinv,
    output logic [1:0][WORD_W-1:0] ccsnoopaddr,
    input  logic [1:0]             iREN,
    input  logic [1:0][WORD_W-1:0] iaddr,
    output logic [1:0]             iwait,
    output logic [1:0][WORD_W-1:0] iload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C1, C2C2, LD1, LD2} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam int         CW         = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;

    state_t        state;
    logic          gnt;
    logic          d_rr;
    logic          i_rr;
    logic [CW-1:0] lat_cnt;

    logic          snp;
    logic          ram_done;
    logic [1:0]    d_miss;
    logic          d_pend;
    logic          wb_sel;
    logic          miss_sel;
    logic          i_sel;

    assign snp      = ~gnt;
    assign ram_done = (ramstate == RAM_ACCESS);
    assign d_miss   = dREN & cctrans;
    assign d_pend   = (|dWEN) || (|d_miss);

    // Ties go to the round-robin pointer; a lone requester wins outright.
    always_comb begin
        wb_sel   = (&dWEN)   ? d_rr : dWEN[1];
        miss_sel = (&d_miss) ? d_rr : d_miss[1];
        i_sel    = (&iREN)   ? i_rr : iREN[1];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            d_rr    <= 1'b0;
            i_rr    <= 1'b0;
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|dWEN) begin
                        state <= WB;
                        gnt   <= wb_sel;
                    end else if (|d_miss) begin
                        state   <= SNOOP;
                        gnt     <= miss_sel;
                        lat_cnt <= '0;
                    end else if ((|iREN) && ram_done) begin
                        i_rr <= ~i_sel;
                    end
                end
                WB: begin
                    if (!dWEN[gnt]) state <= IDLE;
                end
                SNOOP: begin
                    if (lat_cnt == CW'(SNOOP_LAT - 1))
                        state <= cctrans[snp] ? C2C1 : LD1;
                    else
                        lat_cnt <= lat_cnt + 1'b1;
                end
                C2C1: begin
                    if (ram_done) state <= C2C2;
                end
                C2C2: begin
                    if (ram_done) begin
                        state <= IDLE;
                        d_rr  <= snp;
                    end
                end
                LD1: begin
                    if (ram_done) state <= LD2;
                end
                LD2: begin
                    if (ram_done) begin
                        state <= IDLE;
                        d_rr  <= snp;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by nRST so an asserted reset clears them in the same cycle.
    always_comb begin
        dwait       = 2'b11;
        iwait       = 2'b11;
        dload       = '0;
        iload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (nRST) begin
            case (state)
                IDLE: begin
                    if (!d_pend && (|iREN)) begin
                        ramREN       = 1'b1;
                        ramaddr      = iaddr[i_sel];
                        iload[i_sel] = ramload;
                        iwait[i_sel] = !ram_done;
                    end
                end
                WB: begin
                    ramWEN     = dWEN[gnt];
                    ramaddr    = daddr[gnt];
                    ramstore   = dstore[gnt];
                    dwait[gnt] = !(dWEN[gnt] && ram_done);
                end
                SNOOP: begin
                    ccwait[snp]      = 1'b1;
                    ccinv[snp]       = ccwrite[gnt];
                    ccsnoopaddr[snp] = daddr[gnt];
                end
                C2C1, C2C2: begin
                    ccwait[snp]      = 1'b1;
                    ccinv[snp]       = ccwrite[gnt];
                    ccsnoopaddr[snp] = daddr[gnt];
                    ramWEN           = 1'b1;
                    ramaddr          = daddr[snp];
                    ramstore         = dstore[snp];
                    dload[gnt]       = dstore[snp];
                    dwait[gnt]       = !ram_done;
                    dwait[snp]       = !ram_done;
                end
                LD1, LD2: begin
                    ramREN     = 1'b1;
                    ramaddr    = daddr[gnt];
                    dload[gnt] = ramload;
                    dwait[gnt] = !ram_done;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - randomized self-checking bench for coherence_bus_ctrl
module tb_coherence_bus_ctrl;

    localparam int         SNOOP_LAT = 1;
    localparam logic [1:0] FREE      = 2'd0;
    localparam logic [1:0] BUSY      = 2'd1;
    localparam logic [1:0] ACCESS    = 2'd2;
    localparam logic [1:0] ERROR     = 2'd3;

    logic             CLK;
    logic             nRST;
    logic [1:0]       dREN, dWEN, cctrans, ccwrite, iREN;
    logic [1:0]       dwait, ccwait, ccinv, iwait;
    logic [1:0][31:0] daddr, dstore, dload, ccsnoopaddr, iaddr, iload;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    int errors = 0;
    int checks = 0;
    int d_ptr  = 0;
    int i_ptr  = 0;

    coherence_bus_ctrl #(.SNOOP_LAT(SNOOP_LAT), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet_inputs();
        dREN = 2'b00; dWEN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00; iREN = 2'b00;
        ramstate = FREE;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dwait"}, dwait, 2'b11);
        check({tag, "_iwait"}, iwait, 2'b11);
        check({tag, "_cc"}, {ccwait, ccinv}, 4'b0000);
        check({tag, "_snpaddr"}, ccsnoopaddr, 64'h0);
        check({tag, "_ram"}, {ramREN, ramWEN}, 2'b00);
        check({tag, "_dload"}, dload, 64'h0);
        check({tag, "_iload"}, iload, 64'h0);
    endtask

    // Coherent miss: request cycle, SNOOP_LAT snoop cycles, then two words
    // either forwarded from a dirty snooper (written back too) or read from RAM.
    task automatic snoop_txn(input int req, input bit both, input logic wr, input logic dirty,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] d0, input logic [31:0] d1, input int busy);
        int          r, s;
        logic [1:0]  sm;
        logic [31:0] dw;
        bit          acc;
        r  = both ? d_ptr : req;
        s  = 1 - r;
        sm = (s == 1) ? 2'b10 : 2'b01;
        @(negedge CLK);
        quiet_inputs();
        dREN[r] = 1'b1; cctrans[r] = 1'b1; ccwrite[r] = wr; daddr[r] = a;
        dREN[s] = both; cctrans[s] = both; ccwrite[s] = 1'b0; daddr[s] = b;
        #1;
        check("req_dwait", dwait, 2'b11);
        check("req_ram", {ramREN, ramWEN}, 2'b00);
        check("req_ccwait", ccwait, 2'b00);
        for (int k = 0; k < SNOOP_LAT; k++) begin
            @(negedge CLK);
            cctrans[s] = dirty;
            #1;
            check("snp_ccwait", ccwait, sm);
            check("snp_ccinv", ccinv, wr ? sm : 2'b00);
            check("snp_addr", ccsnoopaddr[s], a);
            check("snp_dwait", dwait, 2'b11);
            check("snp_ram", {ramREN, ramWEN}, 2'b00);
        end
        for (int w = 0; w < 2; w++) begin
            for (int bb = 0; bb <= busy; bb++) begin
                @(negedge CLK);
                acc        = (bb == busy);
                dw         = (w == 1) ? d1 : d0;
                ramstate   = acc ? ACCESS : ($urandom_range(0, 1) == 1 ? BUSY : ERROR);
                ramload    = $urandom;
                cctrans[s] = both;
                daddr[r]   = a + 32'(4 * w);
                daddr[s]   = dirty ? a + 32'(4 * w) : b;
                dstore[s]  = dw;
                #1;
                check("ram_strobe", {ramREN, ramWEN}, dirty ? 2'b01 : 2'b10);
                check("ram_addr", ramaddr, a + 32'(4 * w));
                if (dirty) check("ram_store", ramstore, dw);
                check("dload_req", dload[r], dirty ? dw : ramload);
                check("dload_snp", dload[s], 32'h0);
                check("dwait_req", dwait[r], !acc);
                check("dwait_snp", dwait[s], dirty ? !acc : 1'b1);
                check("cc_hold", ccwait, dirty ? sm : 2'b00);
                check("cc_inv_hold", ccinv, (dirty && wr) ? sm : 2'b00);
                check("snoop_iwait", iwait, 2'b11);
            end
        end
        @(negedge CLK);
        quiet_inputs();
        #1;
        check("done_idle", {dwait, ccwait, ramREN, ramWEN}, 6'b110000);
        d_ptr = s;
    endtask

    // Two-word write-back with an optional icache fetch waiting on the other core.
    task automatic wb_txn(input int c, input logic [31:0] a, input logic [31:0] d0,
                          input logic [31:0] d1, input int busy, input bit ireq,
                          input logic [31:0] ia);
        int          o;
        logic [31:0] dw;
        bit          acc;
        o = 1 - c;
        @(negedge CLK);
        quiet_inputs();
        dWEN[c] = 1'b1; daddr[c] = a; dstore[c] = d0;
        iREN[o] = ireq; iaddr[o] = ia;
        #1;
        check("wb_req_ram", {ramREN, ramWEN}, 2'b00);
        check("wb_req_iwait", iwait, 2'b11);
        for (int w = 0; w < 2; w++) begin
            for (int bb = 0; bb <= busy; bb++) begin
                @(negedge CLK);
                acc       = (bb == busy);
                dw        = (w == 1) ? d1 : d0;
                ramstate  = acc ? ACCESS : BUSY;
                ramload   = $urandom;
                daddr[c]  = a + 32'(4 * w);
                dstore[c] = dw;
                #1;
                check("wb_strobe", {ramREN, ramWEN}, 2'b01);
                check("wb_addr", ramaddr, a + 32'(4 * w));
                check("wb_store", ramstore, dw);
                check("wb_dwait_own", dwait[c], !acc);
                check("wb_dwait_oth", dwait[o], 1'b1);
                check("wb_iwait", iwait, 2'b11);
            end
        end
        @(negedge CLK);
        dWEN[c]  = 1'b0;
        ramstate = ACCESS;
        #1;
        check("wb_exit_ram", {ramREN, ramWEN}, 2'b00);
        check("wb_exit_iwait", iwait, 2'b11);
        if (ireq) begin
            @(negedge CLK);
            ramstate = ACCESS;
            ramload  = $urandom;
            #1;
            check("wb_if_strobe", {ramREN, ramWEN}, 2'b10);
            check("wb_if_addr", ramaddr, ia);
            check("wb_if_iwait", iwait[o], 1'b0);
            check("wb_if_iload", iload[o], ramload);
            i_ptr = c;
        end
        @(negedge CLK);
        quiet_inputs();
    endtask

    // Icache fetch in IDLE; stray cctrans without dREN must not matter.
    task automatic ifetch(input bit both, input int c, input logic [31:0] a0,
                          input logic [31:0] a1, input int busy);
        int         srv;
        logic [1:0] sm;
        bit         acc;
        srv = both ? i_ptr : c;
        sm  = (srv == 1) ? 2'b10 : 2'b01;
        for (int bb = 0; bb <= busy; bb++) begin
            @(negedge CLK);
            if (bb == 0) begin
                quiet_inputs();
                cctrans  = 2'($urandom_range(0, 3));
                iaddr[0] = a0;
                iaddr[1] = a1;
                iREN     = both ? 2'b11 : sm;
            end
            acc      = (bb == busy);
            ramstate = acc ? ACCESS : BUSY;
            ramload  = $urandom;
            #1;
            check("if_strobe", {ramREN, ramWEN}, 2'b10);
            check("if_addr", ramaddr, (srv == 1) ? a1 : a0);
            check("if_iwait", iwait, 2'b11 & ~(acc ? sm : 2'b00));
            check("if_iload", iload, (srv == 1) ? {ramload, 32'h0} : {32'h0, ramload});
            check("if_dwait", dwait, 2'b11);
        end
        i_ptr = 1 - srv;
        @(negedge CLK);
        quiet_inputs();
    endtask

    initial begin
        logic [31:0] a, b, d0, d1;
        int          kind, c, busy;
        logic        wr, dirty;
        quiet_inputs();
        daddr = '0; dstore = '0; iaddr = '0; ramload = 32'h0;
        nRST = 1'b0;
        #1;
        iREN = 2'b11; dREN = 2'b11; cctrans = 2'b11; iaddr[0] = 32'h40; ramstate = ACCESS;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge CLK);
        quiet_inputs();
        nRST = 1'b1;

        snoop_txn(0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 0);
        snoop_txn(1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 32'hA, 32'hB, 0);
        snoop_txn(0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h400, 32'h0, 32'h0, 0);
        check("tie_next_ptr", d_ptr[0], 1'b1);
        snoop_txn(0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h400, 32'h0, 32'h0, 0);
        wb_txn(1, 32'h500, 32'h11, 32'h22, 0, 1'b1, 32'h80);
        snoop_txn(0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 32'h0, 3);
        ifetch(1'b1, 0, 32'hC0, 32'hD0, 1);
        ifetch(1'b1, 0, 32'hC4, 32'hD4, 0);

        for (int n = 0; n < 60; n++) begin
            kind  = $urandom_range(0, 3);
            c     = $urandom_range(0, 1);
            busy  = $urandom_range(0, 2);
            wr    = 1'($urandom_range(0, 1));
            dirty = 1'($urandom_range(0, 1));
            a     = 32'($urandom_range(0, 4095)) << 3;
            b     = 32'($urandom_range(0, 4095)) << 3;
            d0    = $urandom;
            d1    = $urandom;
            case (kind)
                0:       snoop_txn(c, 1'b0, wr, dirty, a, b, d0, d1, busy);
                1:       snoop_txn(c, 1'b1, wr, 1'b0, a, b, d0, d1, busy);
                2:       wb_txn(c, a, d0, d1, busy, $urandom_range(0, 1) == 1, b);
                default: ifetch($urandom_range(0, 1) == 1, c, a, b, busy);
            endcase
        end

        // Push the dcache pointer toward core 1, then reset in the middle of C2C1.
        snoop_txn(0, 1'b0, 1'b0, 1'b0, 32'h700, 32'h0, 32'h0, 32'h0, 0);
        @(negedge CLK);
        quiet_inputs();
        dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h800;
        @(negedge CLK);
        cctrans[1] = 1'b1;
        @(negedge CLK);
        cctrans[1] = 1'b0; daddr[1] = 32'h800; dstore[1] = 32'h5A5A; ramstate = BUSY;
        iREN = 2'b11;
        #1;
        check("c2c_before_reset", {ramWEN, ccwait, ccinv}, 5'b11010);
        #1;
        nRST = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge CLK);
        quiet_inputs();
        nRST  = 1'b1;
        d_ptr = 0;
        i_ptr = 0;
        snoop_txn(0, 1'b1, 1'b0, 1'b0, 32'h900, 32'hA00, 32'h0, 32'h0, 0);
        ifetch(1'b1, 1, 32'hE0, 32'hF0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
